// File: rtl/i2c_sda_tx_shaper.sv
// Open-drain SDA transmit shaper: drives one bit per SCL low phase after a programmable
// data-hold delay, samples it back while SCL is high and flags lost arbitration.
module i2c_sda_tx_shaper (
  input  logic       CLK,
  input  logic       RSTB,
  input  logic       EN,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  input  logic       TX_BIT,
  input  logic       TX_VALID,
  output logic       TX_READY,
  input  logic [3:0] HOLD_CYC,
  output logic       SDA_OE,
  output logic       BIT_DONE,
  output logic       ARB_LOST
);

  typedef enum logic [2:0] {
    IDLE, WAIT_LOW, HOLD, WAIT_HIGH, SAMPLE, WAIT_FALL, LOST
  } state_e;

  state_e     state_q, state_d;
  logic       scl_meta_q, scl_s_q, sda_meta_q, sda_s_q;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] hold_lat_q, hold_lat_d;
  logic       bit_q, bit_d;
  logic       sda_oe_q, sda_oe_d;
  logic       arb_lost_q, arb_lost_d;
  logic       armed_q;
  logic       accept;

  // Bus lines idle high, so the synchronizers reset to 1.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      scl_meta_q <= 1'b1;
      scl_s_q    <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_s_q    <= 1'b1;
    end else begin
      scl_meta_q <= SCL_IN;
      scl_s_q    <= scl_meta_q;
      sda_meta_q <= SDA_IN;
      sda_s_q    <= sda_meta_q;
    end
  end

  // armed_q keeps TX_READY low during reset and until the first edge after it.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      hold_lat_q <= 4'd0;
      bit_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
      arb_lost_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_lat_q <= hold_lat_d;
      bit_q      <= bit_d;
      sda_oe_q   <= sda_oe_d;
      arb_lost_q <= arb_lost_d;
      armed_q    <= 1'b1;
    end
  end

  assign TX_READY = armed_q & EN & ~arb_lost_q & (state_q == IDLE);
  assign BIT_DONE = (state_q == SAMPLE);
  assign SDA_OE   = sda_oe_q;
  assign ARB_LOST = arb_lost_q;
  assign accept   = TX_VALID & TX_READY;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_lat_d = hold_lat_q;
    bit_d      = bit_q;
    sda_oe_d   = sda_oe_q;
    arb_lost_d = arb_lost_q;
    if (!EN) begin
      state_d    = IDLE;
      sda_oe_d   = 1'b0;
      arb_lost_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            bit_d      = TX_BIT;
            hold_lat_d = HOLD_CYC;
            state_d    = WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!scl_s_q) begin
            cnt_d   = hold_lat_q;
            state_d = HOLD;
          end
        end
        // The hold always runs to completion, even if SCL rises early.
        HOLD: begin
          if (cnt_q == 4'd0) begin
            sda_oe_d = ~bit_q;
            state_d  = WAIT_HIGH;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        WAIT_HIGH: begin
          if (scl_s_q) state_d = SAMPLE;
        end
        SAMPLE: begin
          if (bit_q && !sda_s_q) begin
            arb_lost_d = 1'b1;
            sda_oe_d   = 1'b0;
            state_d    = LOST;
          end else begin
            state_d = WAIT_FALL;
          end
        end
        WAIT_FALL: begin
          if (!scl_s_q) state_d = IDLE;
        end
        LOST: begin
          sda_oe_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_sda_tx_shaper.sv
// Bench for i2c_sda_tx_shaper: directed scenarios plus randomized bits, with expected
// timing derived from the bus-level rules (2-cycle sync, hold N+1, sample after SCL high).
module tb_i2c_sda_tx_shaper;

  logic       CLK, RSTB, EN, SCL_IN, SDA_IN, TX_BIT, TX_VALID;
  logic [3:0] HOLD_CYC;
  logic       TX_READY, SDA_OE, BIT_DONE, ARB_LOST;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  i2c_sda_tx_shaper dut (
    .CLK(CLK), .RSTB(RSTB), .EN(EN), .SCL_IN(SCL_IN), .SDA_IN(SDA_IN),
    .TX_BIT(TX_BIT), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .HOLD_CYC(HOLD_CYC),
    .SDA_OE(SDA_OE), .BIT_DONE(BIT_DONE), .ARB_LOST(ARB_LOST)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One bit with SCL starting high and the block idle. SCL falls at cycle k, so the
  // block sees it at k+2, enters HOLD at k+3 and moves SDA_OE at k+4+n. SCL rises at m:
  // BIT_DONE is high in cycle m+3 only and a lost arbitration shows at m+4.
  task automatic run_bit(input logic b, input logic [3:0] n, input logic [3:0] n_after,
                         input logic other, input int gap);
    logic old_oe, lost;
    int k, m, p, chg;
    old_oe = SDA_OE;
    lost   = b & ~other;
    chk("ready_idle", TX_READY, 1'b1);
    TX_BIT = b; HOLD_CYC = n; TX_VALID = 1'b1;
    tick();
    TX_VALID = 1'b0; HOLD_CYC = n_after; TX_BIT = ~b;
    chk("ready_busy", TX_READY, 1'b0);
    SCL_IN = 1'b0; k = cyc;
    chg = k + 4 + int'(n);
    wait_until(chg - 1);
    chk("oe_hold", SDA_OE, old_oe);
    tick();
    chk("oe_drive", SDA_OE, ~b);
    repeat (gap) tick();
    SCL_IN = 1'b1; SDA_IN = b & other; m = cyc;
    wait_until(m + 2);
    chk("done_early", BIT_DONE, 1'b0);
    tick();
    chk("done_pulse", BIT_DONE, 1'b1);
    chk("arb_pre", ARB_LOST, 1'b0);
    tick();
    chk("done_end", BIT_DONE, 1'b0);
    chk("arb_lost", ARB_LOST, lost);
    chk("oe_after", SDA_OE, lost ? 1'b0 : ~b);
    if (lost) begin
      repeat (3) tick();
      chk("lost_ready", TX_READY, 1'b0);
      chk("lost_oe", SDA_OE, 1'b0);
      SCL_IN = 1'b0; SDA_IN = 1'b1;
      repeat (4) tick();
      chk("lost_sticky", ARB_LOST, 1'b1);
      chk("lost_ready2", TX_READY, 1'b0);
      EN = 1'b0; TX_VALID = 1'b1; TX_BIT = 1'b0;
      tick();
      chk("en_clr_arb", ARB_LOST, 1'b0);
      chk("en_ready", TX_READY, 1'b0);
      EN = 1'b1; TX_VALID = 1'b0;
      tick();
      chk("rearm_ready", TX_READY, 1'b1);
      chk("rearm_oe", SDA_OE, 1'b0);
    end else begin
      tick();
      SCL_IN = 1'b0; SDA_IN = 1'b1; p = cyc;
      wait_until(p + 2);
      chk("fall_ready_lo", TX_READY, 1'b0);
      tick();
      chk("fall_ready_hi", TX_READY, 1'b1);
      chk("oe_keep", SDA_OE, ~b);
    end
    SCL_IN = 1'b1; SDA_IN = 1'b1;
    repeat (3) tick();
    chk("idle_ready", TX_READY, 1'b1);
  endtask

  // Bits 0,1,0 with TX_VALID held high and HOLD_CYC=0. After the first bit SCL is
  // already low when the block returns to IDLE, so HOLD follows acceptance by one cycle.
  task automatic run_b2b();
    logic bq [3];
    logic old;
    int m, p, chg;
    bq[0] = 1'b0; bq[1] = 1'b1; bq[2] = 1'b0;
    old = SDA_OE;
    TX_BIT = bq[0]; HOLD_CYC = 4'd0; TX_VALID = 1'b1;
    chk("b2b_ready0", TX_READY, 1'b1);
    tick();
    TX_BIT = bq[1];
    chk("b2b_busy0", TX_READY, 1'b0);
    SCL_IN = 1'b0; chg = cyc + 4;
    for (int i = 0; i < 3; i++) begin
      wait_until(chg - 1);
      chk("b2b_oe_hold", SDA_OE, old);
      tick();
      chk("b2b_oe", SDA_OE, ~bq[i]);
      old = ~bq[i];
      SCL_IN = 1'b1; SDA_IN = bq[i]; m = cyc;
      wait_until(m + 3);
      chk("b2b_done", BIT_DONE, 1'b1);
      tick();
      chk("b2b_done_end", BIT_DONE, 1'b0);
      chk("b2b_arb", ARB_LOST, 1'b0);
      tick();
      SCL_IN = 1'b0; SDA_IN = 1'b1; p = cyc;
      wait_until(p + 2);
      chk("b2b_ready_lo", TX_READY, 1'b0);
      tick();
      chk("b2b_ready_hi", TX_READY, 1'b1);
      if (i == 2) TX_VALID = 1'b0;
      tick();
      chk("b2b_ready_1cyc", TX_READY, (i == 2) ? 1'b1 : 1'b0);
      if (i == 0) TX_BIT = bq[2];
      chg = p + 6;
    end
    SCL_IN = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    int k;
    RSTB = 1'b0; EN = 1'b1; SCL_IN = 1'b1; SDA_IN = 1'b1;
    TX_BIT = 1'b1; TX_VALID = 1'b0; HOLD_CYC = 4'd0;
    tick(); tick();
    chk("rst_ready", TX_READY, 1'b0);
    chk("rst_oe", SDA_OE, 1'b0);
    chk("rst_done", BIT_DONE, 1'b0);
    chk("rst_arb", ARB_LOST, 1'b0);
    RSTB = 1'b1;
    #1 chk("ready_before_edge", TX_READY, 1'b0);
    tick();
    chk("ready_first_edge", TX_READY, 1'b1);

    run_bit(1'b0, 4'd3, 4'd3, 1'b1, 0);
    run_bit(1'b0, 4'd5, 4'd5, 1'b1, 2);
    run_bit(1'b1, 4'd1, 4'd1, 1'b0, 0);
    run_b2b();
    run_bit(1'b0, 4'd2, 4'd9, 1'b1, 1);

    // Reset in the middle of a long hold while SDA is being pulled low.
    TX_BIT = 1'b1; HOLD_CYC = 4'd15; TX_VALID = 1'b1;
    chk("pre_rst_oe_prev", SDA_OE, 1'b1);
    tick();
    TX_VALID = 1'b0; SCL_IN = 1'b0; k = cyc;
    wait_until(k + 6);
    chk("rst_hold_oe", SDA_OE, 1'b1);
    #2 RSTB = 1'b0;
    #1 chk("rst_async_oe", SDA_OE, 1'b0);
    chk("rst_async_ready", TX_READY, 1'b0);
    tick();
    SCL_IN = 1'b1; SDA_IN = 1'b1;
    tick();
    RSTB = 1'b1;
    #1 chk("rerst_ready_pre", TX_READY, 1'b0);
    tick();
    chk("rerst_ready", TX_READY, 1'b1);
    chk("rerst_oe", SDA_OE, 1'b0);
    run_bit(1'b0, 4'd2, 4'd2, 1'b1, 1);

    for (int r = 0; r < 16; r++) begin
      run_bit(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (observed running, expected finished)");
    $fatal(1, "timeout");
  end

endmodule
